// File: rtl/reflet_uart_pkg.sv
// reflet_uart_pkg: register offsets, STATUS bit positions and FSM
// encodings shared by the reflet UART with FIFOs.
package reflet_uart_pkg;

    localparam logic [2:0] REG_TXDATA = 3'd0;
    localparam logic [2:0] REG_RXDATA = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_DIV    = 3'd3;
    localparam logic [2:0] REG_IRQEN  = 3'd4;

    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_TX_EMPTY = 1;
    localparam int STAT_RX_EMPTY = 2;
    localparam int STAT_RX_FULL  = 3;
    localparam int STAT_OVERRUN  = 4;
    localparam int STAT_TX_BUSY  = 5;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/reflet_fifo.sv
// reflet_fifo: synchronous FIFO of 2**depth_log2 entries.
// Ports: clk, reset (sync, active-high), push/din, pop/dout (head, 0 when
// empty), full, empty. Push on full succeeds only if a pop frees a slot;
// pop on empty is ignored.
module reflet_fifo #(
    parameter int width      = 8,
    parameter int depth_log2 = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << depth_log2;
    localparam logic [depth_log2:0] CNT_FULL = {1'b1, {depth_log2{1'b0}}};

    logic [width-1:0]      mem_q [DEPTH];
    logic [depth_log2-1:0] wr_ptr_q, wr_ptr_d;
    logic [depth_log2-1:0] rd_ptr_q, rd_ptr_d;
    logic [depth_log2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_FULL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + depth_log2'(1);
        if (do_pop) rd_ptr_d = rd_ptr_q + depth_log2'(1);
        if (do_push && !do_pop) begin
            count_d = count_q + (depth_log2 + 1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (depth_log2 + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/reflet_uart_fifo.sv
// reflet_uart_fifo: memory-mapped UART with TX/RX FIFOs, runtime baud
// divisor and line status, for the OR-combined reflet data bus.
// Ports: clk, reset (sync, active-high), enable/addr/write_en/data_in,
// data_out (0 when unselected), rx/tx (serial, idle high).
// Build option REFLET_UART_INTERRUPT_EN adds irq and the IRQEN register.
module reflet_uart_fifo
    import reflet_uart_pkg::*;
#(
    parameter int base_addr_size  = 15,
    parameter int base_addr       = 0,
    parameter int clk_freq        = 1000000,
    parameter int baud_rate       = 9600,
    parameter int fifo_depth_log2 = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [base_addr_size-1:0] addr,
    input  logic                      write_en,
    input  logic [7:0]                data_in,
    output logic [7:0]                data_out,
    input  logic                      rx,
    output logic                      tx
`ifdef REFLET_UART_INTERRUPT_EN
    ,
    output logic                      irq
`endif
);
    localparam int DIV_INT = clk_freq / baud_rate - 1;
    localparam logic [15:0] DIV_RST = DIV_INT[15:0];
`ifdef REFLET_UART_INTERRUPT_EN
    localparam int NUM_REGS = 5;
`else
    localparam int NUM_REGS = 4;
`endif
    localparam logic [base_addr_size-1:0] BASE = base_addr[base_addr_size-1:0];
    localparam logic [base_addr_size-1:0] NREGS = NUM_REGS[base_addr_size-1:0];

    // Bus decode; addresses below base wrap to large offsets and miss.
    logic [base_addr_size-1:0] off;
    logic [2:0] off3;
    logic sel, acc_start, acc_wr, acc_rd;

    assign off  = addr - BASE;
    assign off3 = off[2:0];
    assign sel  = enable && (off < NREGS);

    logic       prev_sel_q, prev_sel_d;
    logic [2:0] prev_off_q, prev_off_d;
    logic       prev_we_q, prev_we_d;

    // Side effects fire only on the first cycle of a held access.
    assign acc_start = sel && (!prev_sel_q || prev_off_q != off3
                               || prev_we_q != write_en);
    assign acc_wr = acc_start && write_en;
    assign acc_rd = acc_start && !write_en;

    logic tx_push, tx_pop, tx_full, tx_empty;
    logic rx_push, rx_pop, rx_full, rx_empty, rx_drop;
    logic [7:0] tx_dout, rx_dout;
    logic stat_rd, div_wr, tx_busy;

    assign tx_push = acc_wr && off3 == REG_TXDATA;
    assign rx_pop  = acc_rd && off3 == REG_RXDATA;
    assign stat_rd = acc_rd && off3 == REG_STATUS;
    assign div_wr  = acc_wr && off3 == REG_DIV;
    assign rx_drop = rx_push && rx_full && !rx_pop;

    logic [15:0] divisor_q, divisor_d;
    logic div_hi_q, div_hi_d;
    logic overrun_q, overrun_d;

    always_comb begin
        divisor_d  = divisor_q;
        div_hi_d   = div_hi_q;
        overrun_d  = overrun_q;
        prev_sel_d = sel;
        prev_off_d = off3;
        prev_we_d  = write_en;
        if (div_wr) begin
            if (div_hi_q) divisor_d[15:8] = data_in;
            else divisor_d[7:0] = data_in;
            div_hi_d = !div_hi_q;
        end
        if (stat_rd) overrun_d = 1'b0;
        if (rx_drop) overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            divisor_q  <= DIV_RST;
            div_hi_q   <= 1'b0;
            overrun_q  <= 1'b0;
            prev_sel_q <= 1'b0;
            prev_off_q <= '0;
            prev_we_q  <= 1'b0;
        end else begin
            divisor_q  <= divisor_d;
            div_hi_q   <= div_hi_d;
            overrun_q  <= overrun_d;
            prev_sel_q <= prev_sel_d;
            prev_off_q <= prev_off_d;
            prev_we_q  <= prev_we_d;
        end
    end

    // Transmitter: the divisor is latched per frame so DIV writes
    // only affect the next frame.
    tx_state_t   tx_state_q;
    logic        tx_q;
    logic [15:0] tx_cnt_q, tx_div_q;
    logic [2:0]  tx_idx_q;
    logic [7:0]  tx_shift_q;
    logic        tx_bit_end;

    assign tx_bit_end = (tx_cnt_q == '0);
    assign tx_pop = !tx_empty && (tx_state_q == TX_IDLE
                    || (tx_state_q == TX_STOP && tx_bit_end));
    assign tx_busy = (tx_state_q != TX_IDLE) || !tx_empty;
    assign tx = tx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_q       <= 1'b1;
            tx_cnt_q   <= '0;
            tx_div_q   <= DIV_RST;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
        end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
            unique case (tx_state_q)
                TX_IDLE, TX_STOP: begin
                    if (tx_pop) begin
                        tx_state_q <= TX_START;
                        tx_q       <= 1'b0;
                        tx_cnt_q   <= divisor_q;
                        tx_div_q   <= divisor_q;
                        tx_shift_q <= tx_dout;
                    end else if (tx_state_q == TX_STOP && tx_bit_end) begin
                        tx_state_q <= TX_IDLE;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_state_q <= TX_DATA;
                        tx_q       <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_cnt_q   <= tx_div_q;
                        tx_idx_q   <= '0;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt_q <= tx_div_q;
                        if (tx_idx_q == 3'd7) begin
                            tx_state_q <= TX_STOP;
                            tx_q       <= 1'b1;
                        end else begin
                            tx_q       <= tx_shift_q[0];
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_idx_q   <= tx_idx_q + 3'd1;
                        end
                    end
                end
            endcase
        end
    end

    // Receiver: 2-flop synchroniser, falling-edge start detect,
    // start bit rechecked half a bit later to reject glitches.
    rx_state_t   rx_state_q;
    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    logic [15:0] rx_cnt_q, rx_div_q;
    logic [2:0]  rx_idx_q;
    logic [7:0]  rx_shift_q;
    logic        rx_bit_end;

    assign rx_bit_end = (rx_cnt_q == '0);
    assign rx_push = rx_state_q == RX_STOP && rx_bit_end && rx_sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= DIV_RST;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            rx_cnt_q  <= rx_cnt_q - 16'd1;
            unique case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= divisor_q >> 1;
                        rx_div_q   <= divisor_q;
                    end
                end
                RX_START: begin
                    if (rx_bit_end) begin
                        if (rx_sync_q) begin
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_state_q <= RX_DATA;
                            rx_cnt_q   <= rx_div_q;
                            rx_idx_q   <= '0;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_bit_end) begin
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_cnt_q   <= rx_div_q;
                        if (rx_idx_q == 3'd7) rx_state_q <= RX_STOP;
                        else rx_idx_q <= rx_idx_q + 3'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_bit_end) rx_state_q <= RX_IDLE;
                end
            endcase
        end
    end

    reflet_fifo #(
        .width     (8),
        .depth_log2(fifo_depth_log2)
    ) u_tx_fifo (
        .clk  (clk),
        .reset(reset),
        .push (tx_push),
        .pop  (tx_pop),
        .din  (data_in),
        .dout (tx_dout),
        .full (tx_full),
        .empty(tx_empty)
    );

    reflet_fifo #(
        .width     (8),
        .depth_log2(fifo_depth_log2)
    ) u_rx_fifo (
        .clk  (clk),
        .reset(reset),
        .push (rx_push),
        .pop  (rx_pop),
        .din  (rx_shift_q),
        .dout (rx_dout),
        .full (rx_full),
        .empty(rx_empty)
    );

    logic [7:0] status;

    always_comb begin
        status = '0;
        status[STAT_TX_FULL]  = tx_full;
        status[STAT_TX_EMPTY] = tx_empty;
        status[STAT_RX_EMPTY] = rx_empty;
        status[STAT_RX_FULL]  = rx_full;
        status[STAT_OVERRUN]  = overrun_q;
        status[STAT_TX_BUSY]  = tx_busy;
    end

`ifdef REFLET_UART_INTERRUPT_EN
    logic [2:0] irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    always_comb begin
        irq_en_d = irq_en_q;
        if (acc_wr && off3 == REG_IRQEN) irq_en_d = data_in[2:0];
        irq_d = |(irq_en_q & {overrun_q, tx_empty, !rx_empty});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    always_comb begin
        data_out = '0;
        if (sel) begin
            case (off3)
                REG_RXDATA: data_out = rx_dout;
                REG_STATUS: data_out = status;
                REG_DIV: data_out = div_hi_q ? divisor_q[15:8] : divisor_q[7:0];
`ifdef REFLET_UART_INTERRUPT_EN
                REG_IRQEN: data_out = {5'd0, irq_en_q};
`endif
                default: data_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_reflet_uart_fifo.sv
// tb_reflet_uart_fifo: register table checks, serial TX/RX frames with
// queue reference model, overrun, glitch, divisor change and reset.
`timescale 1ns/1ps
module tb_reflet_uart_fifo;
    localparam int AW   = 15;
    localparam int BASE = 8;
    localparam int BT   = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic write_en = 1'b0;
    logic rx = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic tx;
`ifdef REFLET_UART_INTERRUPT_EN
    logic irq;
`endif

    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reflet_uart_fifo #(
        .base_addr_size (AW),
        .base_addr      (BASE),
        .clk_freq       (96000),
        .baud_rate      (9600),
        .fifo_depth_log2(4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .addr    (addr),
        .write_en(write_en),
        .data_in (data_in),
        .data_out(data_out),
        .rx      (rx),
        .tx      (tx)
`ifdef REFLET_UART_INTERRUPT_EN
        ,
        .irq     (irq)
`endif
    );

    initial begin
        #900000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic bus_rd(input logic en, input int a, input int hold,
                          output logic [7:0] d);
        @(negedge clk);
        enable = en;
        addr = AW'(a);
        write_en = 1'b0;
        #1 d = data_out;
        repeat (hold) @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic rd(input int o, output logic [7:0] d);
        bus_rd(1'b1, BASE + o, 1, d);
    endtask

    task automatic wr(input int o, input logic [7:0] v);
        @(negedge clk);
        enable = 1'b1;
        addr = AW'(BASE + o);
        write_en = 1'b1;
        data_in = v;
        @(negedge clk);
        enable = 1'b0;
        write_en = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stopb,
                           input int bt);
        logic [9:0] f;
        f = {stopb, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            @(negedge clk);
            rx = f[b];
            repeat (bt - 1) @(negedge clk);
        end
        @(negedge clk);
        rx = 1'b1;
    endtask

    // Checks level on every clock of the frame and decodes mid-bit.
    task automatic check_frame(input logic [7:0] exp, input int bt,
                               input int maxwait, input string nm);
        int w;
        int bad;
        logic [9:0] want;
        logic [7:0] got;
        want = {1'b1, exp, 1'b0};
        w = 0;
        @(negedge clk);
        while (tx !== 1'b0 && w < maxwait) begin
            @(negedge clk);
            w++;
        end
        if (tx !== 1'b0) begin
            chk({nm, "_start_timeout"}, {31'd0, tx}, 32'd0);
            return;
        end
        bad = 0;
        got = '0;
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < bt; k++) begin
                if (!(b == 0 && k == 0)) @(negedge clk);
                if (tx !== want[b]) bad++;
                if (k == bt / 2 && b >= 1 && b <= 8) got[b-1] = tx;
            end
        end
        chk(nm, {23'd0, bad == 0, got}, {23'd0, 1'b1, exp});
    endtask

    typedef struct {
        logic       en;
        int         a;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [7:0] d;
        logic [7:0] b;
        logic [7:0] q[$];
        int n;
        int w;
        int lows;

        vecs[0] = '{1'b1, BASE + 0, 8'h00};
        vecs[1] = '{1'b1, BASE + 1, 8'h00};
        vecs[2] = '{1'b1, BASE + 2, 8'h06};
        vecs[3] = '{1'b1, BASE + 3, 8'h09};
        vecs[4] = '{1'b1, BASE + 4, 8'h00};
        vecs[5] = '{1'b1, BASE - 1, 8'h00};
        vecs[6] = '{1'b0, BASE + 2, 8'h00};
        vecs[7] = '{1'b1, BASE + 2, 8'h06};

        repeat (3) @(negedge clk);
        chk("tx_in_reset", {31'd0, tx}, 32'd1);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            bus_rd(vecs[i].en, vecs[i].a, 1, d);
            chk($sformatf("reg_vec%0d", i), {24'd0, d}, {24'd0, vecs[i].exp});
        end
        chk("tx_idle_after_reset", {31'd0, tx}, 32'd1);

        fork
            begin
                wr(0, 8'h48);
                wr(0, 8'h65);
                repeat (30) @(negedge clk);
                rd(2, d);
                chk("status_tx_busy", {24'd0, d}, 32'h24);
            end
            begin
                check_frame(8'h48, BT, 20, "tx_frame_48");
                check_frame(8'h65, BT, 0, "tx_frame_65_b2b");
            end
        join
        rd(2, d);
        chk("status_tx_done", {24'd0, d}, 32'h06);

        send_rx(8'h5A, 1'b1, BT);
        send_rx(8'h3C, 1'b1, BT);
        repeat (3) @(negedge clk);
        rd(2, d);
        chk("status_rx_ready", {24'd0, d}, 32'h02);
        bus_rd(1'b1, BASE + 1, 3, d);
        chk("rxdata_held_read", {24'd0, d}, 32'h5A);
        rd(1, d);
        chk("rxdata_second", {24'd0, d}, 32'h3C);
        rd(2, d);
        chk("status_rx_drained", {24'd0, d}, 32'h06);

        q.delete();
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            send_rx(b, 1'b1, BT);
        end
        repeat (3) @(negedge clk);
        rd(2, d);
        chk("status_overrun", {24'd0, d}, 32'h1A);
        rd(2, d);
        chk("status_overrun_cleared", {24'd0, d}, 32'h0A);
        for (int i = 0; i < 16; i++) begin
            rd(1, d);
            chk($sformatf("overrun_byte%0d", i), {24'd0, d}, {24'd0, q[i]});
        end
        rd(2, d);
        chk("status_after_overrun_drain", {24'd0, d}, 32'h06);

        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (150) @(negedge clk);
        rd(2, d);
        chk("glitch_no_byte", {24'd0, d}, 32'h06);
        send_rx(8'hA5, 1'b0, BT);
        repeat (150) @(negedge clk);
        rd(2, d);
        chk("framing_discard", {24'd0, d}, 32'h06);
        send_rx(8'hC3, 1'b1, BT);
        repeat (3) @(negedge clk);
        rd(1, d);
        chk("rx_after_framing", {24'd0, d}, 32'hC3);

        q.delete();
        for (int i = 0; i < 18; i++) q.push_back(8'($urandom));
        fork
            begin
                for (int i = 0; i < 18; i++) wr(0, q[i]);
                rd(2, d);
                chk("status_tx_full", {24'd0, d}, 32'h25);
            end
            begin
                for (int i = 0; i < 17; i++)
                    check_frame(q[i], BT, (i == 0) ? 20 : 0,
                                $sformatf("tx_rand%0d", i));
            end
        join
        rd(2, d);
        chk("tx_overflow_dropped", {24'd0, d}, 32'h06);

        q.delete();
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            send_rx(b, 1'b1, BT);
        end
        repeat (3) @(negedge clk);
        while (q.size() > 0) begin
            rd(1, d);
            chk("rx_rand", {24'd0, d}, {24'd0, q.pop_front()});
        end
        rd(2, d);
        chk("status_rx_rand_drained", {24'd0, d}, 32'h06);

        fork
            begin
                wr(0, 8'hC9);
                repeat (30) @(negedge clk);
                wr(3, 8'h04);
                wr(3, 8'h00);
                wr(0, 8'h3E);
            end
            begin
                check_frame(8'hC9, 10, 20, "div_frame_old");
                check_frame(8'h3E, 5, 0, "div_frame_new");
            end
        join
        rd(3, d);
        chk("div_readback_lo", {24'd0, d}, 32'h04);
        wr(3, 8'h0A);
        wr(3, 8'h00);
        rd(3, d);
        chk("div_readback_0a", {24'd0, d}, 32'h0A);

        send_rx(8'h77, 1'b1, 11);
        repeat (3) @(negedge clk);
        wr(0, 8'h11);
        wr(0, 8'h22);
        wr(0, 8'h33);
        rd(2, d);
        chk("status_before_reset", {24'd0, d}, 32'h20);
        w = 0;
        while (tx !== 1'b0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("tx_low_before_reset", {31'd0, tx}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("tx_high_after_reset_edge", {31'd0, tx}, 32'd1);
        reset = 1'b0;
        rd(2, d);
        chk("status_after_mid_reset", {24'd0, d}, 32'h06);
        rd(3, d);
        chk("div_after_mid_reset", {24'd0, d}, 32'h09);
        rd(1, d);
        chk("rxdata_after_mid_reset", {24'd0, d}, 32'h00);
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("tx_quiet_after_reset", lows, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/reflet_uart_fifo.md
Name: reflet_uart_fifo

Overview:
Memory-mapped UART peripheral for the reflet system bus, and the successor of the single-byte reflet_uart.
- Adds parametrised TX and RX FIFOs, a runtime-programmable baud divisor and a line-status register.
- Sits on the shared OR-combined data bus beside ROM/RAM, and is selected by the CPU through enable and addr.
- Drives data_out to zero when not selected, so bus merging is a plain OR.

Parameters:
base_addr_size, 15, width of the addr port
base_addr, 0, address of register 0; the block decodes base_addr..base_addr+3
clk_freq, 1000000, system clock in Hz
baud_rate, 9600, reset baud; reset divisor = clk_freq/baud_rate - 1, truncated to 16 bits
fifo_depth_log2, 4, each FIFO holds 2**fifo_depth_log2 bytes

Ports:
clk  in  1  system clock; all logic is on the rising edge
reset  in  1  synchronous, active-high; one clock; sampled on the rising edge of clk
enable  in  1  bus select for this peripheral
addr  in  base_addr_size  bus address
write_en  in  1  1 = write, 0 = read
data_in  in  8  write data
data_out  out  8  read data; 0 when not selected
rx  in  1  serial input; idle high
tx  out  1  serial output; idle high

Behaviour:
- Reset values: tx=1, data_out=0, both FIFOs empty, divisor=reset divisor, RX overrun flag=0, TX/RX FSMs in IDLE.
- Reset mid-frame aborts both directions immediately; tx returns to 1 on the next edge.
- Register map (offset = addr-base_addr; other addresses are not decoded):
  - 0 TXDATA: write pushes data_in into the TX FIFO; the write is dropped if the FIFO is full. Reads return 0.
  - 1 RXDATA: read returns the RX FIFO head (0 if empty).
  - 2 STATUS, read-only:
    - bit0 tx_full
    - bit1 tx_empty
    - bit2 rx_empty
    - bit3 rx_full
    - bit4 overrun
    - bit5 tx_busy (FSM not IDLE or FIFO not empty)
    - Reading STATUS clears overrun.
  - 3 DIVLO/DIVHI: a write alternates low byte then high byte, toggled by a byte-pointer flag reset to low. The new divisor takes effect at the next frame start. A read returns the byte the pointer selects.
- data_out is combinational from the current selection.
- Side effects (RX pop, overrun clear, DIV pointer toggle) happen once per access, on the first cycle of a selected access. An access starts when (enable, offset, write_en) differs from the previous cycle or enable was low. Multi-cycle CPU accesses therefore pop exactly once.
- Baud tick: a 16-bit counter reloads with the divisor; one bit period = divisor+1 clocks.
- TX FSM:
  - IDLE → START when the FIFO is non-empty; the byte is popped on entry.
  - START (tx=0, 1 bit) → DATA (8 bits, LSB first) → STOP (tx=1, 1 bit) → IDLE, or straight to START if the FIFO is non-empty (back-to-back frames).
- RX FSM:
  - rx passes through a 2-flop synchroniser first.
  - IDLE → START on a falling edge. In START, rx is sampled at half a bit period; if it is high the FSM returns to IDLE (glitch).
  - DATA samples 8 bits at bit centres. STOP samples the stop bit.
  - Stop bit = 1: the byte is pushed. Stop bit = 0: the frame is discarded (framing error, no flag).
  - Push onto a full RX FIFO drops the new byte and sets overrun.
- FIFO simultaneous push+pop: when full, the pop frees a slot and the push succeeds; when empty, the push succeeds and the pop reads 0 without popping.

Optional Feature:
REFLET_UART_INTERRUPT_EN
- With the macro defined, the block adds output port irq (1 bit, reset 0) and register offset 4 IRQEN:
  - bit0 rx_not_empty enable
  - bit1 tx_empty enable
  - bit2 overrun enable
  - irq = OR of enabled conditions, registered (one cycle latency).
- Without the macro, there is no irq port, offset 4 is undecoded, and behaviour is otherwise identical.

Decomposition:
- Package reflet_uart_pkg:
  - register offsets (REG_TXDATA=0, REG_RXDATA=1, REG_STATUS=2, REG_DIV=3, REG_IRQEN=4)
  - STATUS bit positions
  - TX/RX FSM state encodings
- Sub-module reflet_fifo (parameters width, depth_log2; ports clk, reset, push, pop, din, dout, full, empty), instantiated twice for TX and RX.

Test Plan:
- Reset with clk_freq=96000, baud_rate=9600 (divisor 9): after reset, tx=1 and STATUS reads 0x06 (tx_empty, rx_empty).
- Write 0x48,0x65 to TXDATA: tx shows start bit, 0x48 LSB-first at 10 clocks/bit, stop bit, then 0x65 immediately with no idle gap; tx_busy clears after the second stop bit.
- Drive frame 0x5A on rx: STATUS bit2 goes 0; a 3-cycle held read of RXDATA returns 0x5A and pops once, so rx_empty=1 afterwards.
- Send 17 RX bytes with fifo_depth_log2=4 and no reads: overrun=1, the first 16 bytes are intact, byte 17 is lost; a STATUS read clears overrun.
- 1-clock low glitch on rx: no byte is received. Frame with stop bit 0: the byte is discarded.
- Write DIV low=0x04, high=0x00 mid-frame: the current frame keeps 10 clk/bit and the next frame uses 5 clk/bit. Reset asserted mid-frame: tx=1 on the next edge and FIFOs are empty.
